mem_data_port_arbiter: RTL and testbench

//  - Shares the single data read/write port of the unified 16-bit memory between requesters:

---
 rtl/mem_data_port_arbiter_if.sv | 38 +++
 rtl/mem_data_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_data_port_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_data_port_arbiter_if.sv
// Requester-side bundle for the shared memory data port arbiter.
// Port 0 = CPU load/store path, port 1 = debug/DMA loader.
//   req/we/addr/wdata : request, held stable until the matching gnt
//   gnt0/gnt1         : request accepted this cycle (combinational)
//   stall0            : port 0 requesting but not granted
//   rvalid0/rvalid1   : load response for that port is on rdata this cycle
//   rdata             : shared response data
interface mem_data_port_arbiter_if;
   localparam int unsigned AW = 15;
   localparam int unsigned DW = 16;

   logic          req0;
   logic          we0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] wdata0;
   logic          gnt0;
   logic          stall0;
   logic          rvalid0;

   logic          req1;
   logic          we1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata1;
   logic          gnt1;
   logic          rvalid1;

   logic [DW-1:0] rdata;

   modport master (
      output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
      input  gnt0, stall0, rvalid0, gnt1, rvalid1, rdata
   );

   modport slave (
      input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
      output gnt0, stall0, rvalid0, gnt1, rvalid1, rdata
   );
endinterface

// File: rtl/mem_data_port_arbiter.sv
// Arbiter sharing the single data read/write port of the unified 16-bit memory.
// Port 0 has fixed priority; after MAX_WAIT consecutive port-1 denials one cycle
// is reserved for port 1. Load responses return READ_LATENCY cycles after grant,
// tagged with the issuing port.
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : requester handshakes, grants, stall, response valid/data
//   mem_raddr       : memory read address (granted address, else 0)
//   mem_rdata       : memory read data, passed straight through to rdata
//   mem_wen/waddr/wdata : memory write port, driven for a granted store
module mem_data_port_arbiter #(
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned MAX_WAIT     = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   mem_data_port_arbiter_if.slave   bus,
   output logic [14:0]              mem_raddr,
   input  logic [15:0]              mem_rdata,
   output logic                     mem_wen,
   output logic [14:0]              mem_waddr,
   output logic [15:0]              mem_wdata
);
   localparam int unsigned AW = 15;
   localparam int unsigned DW = 16;
   localparam int unsigned CW = 4;
   localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

   typedef enum logic [0:0] {ST_NORMAL, ST_FORCE} state_t;

   state_t                  state;
   logic [CW-1:0]           wait_cnt;
   logic [CW-1:0]           wait_nxt;
   logic                    gnt0;
   logic                    gnt1;
   logic                    any_gnt;
   logic                    g_we;
   logic [AW-1:0]           g_addr;
   logic [DW-1:0]           g_wdata;
   logic                    load_gnt;
   logic [READ_LATENCY-1:0] pipe_v;
   logic [READ_LATENCY-1:0] pipe_id;

   // Grant selection; held off entirely while in reset
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_n) begin
         case (state)
            ST_NORMAL: begin
               gnt0 = bus.req0;
               gnt1 = bus.req1 & ~bus.req0;
            end
            ST_FORCE: begin
               gnt1 = bus.req1;
            end
            default: ;
         endcase
      end
   end

   assign bus.gnt0   = gnt0;
   assign bus.gnt1   = gnt1;
   assign bus.stall0 = rst_n & bus.req0 & ~gnt0;

   // Mux the winning request onto the memory port
   assign any_gnt  = gnt0 | gnt1;
   assign g_we     = gnt1 ? bus.we1    : bus.we0;
   assign g_addr   = gnt1 ? bus.addr1  : bus.addr0;
   assign g_wdata  = gnt1 ? bus.wdata1 : bus.wdata0;
   assign load_gnt = any_gnt & ~g_we;

   assign mem_wen   = any_gnt & g_we;
   assign mem_waddr = mem_wen ? g_addr  : AW'(0);
   assign mem_wdata = mem_wen ? g_wdata : DW'(0);
   assign mem_raddr = any_gnt ? g_addr  : AW'(0);

   // Starvation count of consecutive port-1 denials, saturating
   always_comb begin
      wait_nxt = wait_cnt;
      if (!bus.req1 || gnt1) begin
         wait_nxt = '0;
      end else if (wait_cnt < WAIT_MAX) begin
         wait_nxt = wait_cnt + CW'(1);
      end
   end

   // Enter FORCE on the denial that reaches the limit so port 1 wins the very next cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_NORMAL;
         wait_cnt <= '0;
      end else begin
         case (state)
            ST_NORMAL: begin
               wait_cnt <= wait_nxt;
               if (wait_nxt == WAIT_MAX) state <= ST_FORCE;
            end
            ST_FORCE: begin
               state    <= ST_NORMAL;
               wait_cnt <= '0;
            end
            default: begin
               state    <= ST_NORMAL;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   // Response tag pipe, aligned with the memory's fixed read latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_v  <= '0;
         pipe_id <= '0;
      end else begin
         pipe_v[0]  <= load_gnt;
         pipe_id[0] <= gnt1;
         for (int i = 1; i < int'(READ_LATENCY); i++) begin
            pipe_v[i]  <= pipe_v[i-1];
            pipe_id[i] <= pipe_id[i-1];
         end
      end
   end

   assign bus.rvalid0 = pipe_v[READ_LATENCY-1] & ~pipe_id[READ_LATENCY-1];
   assign bus.rvalid1 = pipe_v[READ_LATENCY-1] &  pipe_id[READ_LATENCY-1];
   assign bus.rdata   = mem_rdata;
endmodule

// File: tb/tb_mem_data_port_arbiter.sv
// Directed bench for mem_data_port_arbiter with a 2-cycle-latency memory model.
module tb_mem_data_port_arbiter;
   logic        clk;
   logic        rst_n;
   logic [14:0] mem_raddr;
   logic [15:0] mem_rdata;
   logic        mem_wen;
   logic [14:0] mem_waddr;
   logic [15:0] mem_wdata;

   int checks = 0;
   int errors = 0;

   mem_data_port_arbiter_if bus ();

   mem_data_port_arbiter #(.READ_LATENCY(2), .MAX_WAIT(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .mem_raddr (mem_raddr),
      .mem_rdata (mem_rdata),
      .mem_wen   (mem_wen),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: write lands at the edge, read data appears two cycles after the address
   logic [15:0] mem [0:32767];
   logic [15:0] rd1, rd2;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd1 <= '0;
         rd2 <= '0;
      end else begin
         if (mem_wen) mem[mem_waddr] <= mem_wdata;
         rd1 <= mem[mem_raddr];
         rd2 <= rd1;
      end
   end
   assign mem_rdata = rd2;

   typedef struct {
      logic        req0, we0;
      logic [14:0] a0;
      logic [15:0] d0;
      logic        req1, we1;
      logic [14:0] a1;
      logic [15:0] d1;
      logic        g0, g1, st0, rv0, rv1;
      logic [15:0] rd;
   } vec_t;

   vec_t vt[$];

   function automatic void add(input logic r0, input logic w0, input logic [14:0] a0,
                               input logic [15:0] d0, input logic r1, input logic w1,
                               input logic [14:0] a1, input logic [15:0] d1,
                               input logic g0, input logic g1, input logic st0,
                               input logic rv0, input logic rv1, input logic [15:0] rd);
      vec_t v;
      v.req0 = r0; v.we0 = w0; v.a0 = a0; v.d0 = d0;
      v.req1 = r1; v.we1 = w1; v.a1 = a1; v.d1 = d1;
      v.g0 = g0; v.g1 = g1; v.st0 = st0; v.rv0 = rv0; v.rv1 = rv1; v.rd = rd;
      vt.push_back(v);
   endfunction

   function automatic void idle(input logic rv0, input logic rv1, input logic [15:0] rd);
      add(0,0,0,0, 0,0,0,0, 0,0,0, rv0,rv1,rd);
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r0, input logic w0, input logic [14:0] a0,
                        input logic [15:0] d0, input logic r1, input logic w1,
                        input logic [14:0] a1, input logic [15:0] d1);
      bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
      bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
   endtask

   task automatic chk_quiet(input string nm);
      chk({nm, " gnt0"},    16'(bus.gnt0),    16'h0);
      chk({nm, " gnt1"},    16'(bus.gnt1),    16'h0);
      chk({nm, " stall0"},  16'(bus.stall0),  16'h0);
      chk({nm, " rvalid0"}, 16'(bus.rvalid0), 16'h0);
      chk({nm, " rvalid1"}, 16'(bus.rvalid1), 16'h0);
      chk({nm, " mem_wen"}, 16'(mem_wen),     16'h0);
      chk({nm, " raddr"},   16'(mem_raddr),   16'h0);
   endtask

   initial begin
      vec_t        v;
      logic        ewen;
      logic [14:0] eaddr;
      logic [15:0] edata;
      string       nm;

      // Table: one row per cycle, inputs and expected outputs
      add(0,0,0,0,          1,1,15'h10,16'hBEEF, 0,1,0, 0,0,0);      // 0 p1 store BEEF@10
      idle(0,0,0);                                                    // 1
      add(1,0,15'h10,0,     0,0,0,0,             1,0,0, 0,0,0);      // 2 p0 load 10
      idle(0,0,0);                                                    // 3
      idle(1,0,16'hBEEF);                                             // 4 latency 2
      idle(0,0,0);                                                    // 5 exactly once
      add(0,0,0,0,          1,1,15'h20,16'h1234, 0,1,0, 0,0,0);      // 6 p1 store 1234@20
      add(1,0,15'h20,0,     0,0,0,0,             1,0,0, 0,0,0);      // 7 p0 load 20
      idle(0,0,0);                                                    // 8
      idle(1,0,16'h1234);                                             // 9 new data
      add(1,0,15'h10,0,     0,0,0,0,             1,0,0, 0,0,0);      // 10 p0 load t
      add(0,0,0,0,          1,0,15'h20,0,        0,1,0, 0,0,0);      // 11 p1 load t+1
      add(1,0,15'h10,0,     0,0,0,0,             1,0,0, 1,0,16'hBEEF); // 12 p0 load t+2
      idle(0,1,16'h1234);                                             // 13
      idle(1,0,16'hBEEF);                                             // 14
      idle(0,0,0);                                                    // 15
      for (int i = 0; i < 4; i++)                                     // 16-19 contention
         add(1,0,15'h10,0,  1,0,15'h20,0,        1,0,0, (i >= 2),0, (i >= 2) ? 16'hBEEF : 16'h0);
      add(1,0,15'h10,0,     1,0,15'h20,0,        0,1,1, 1,0,16'hBEEF); // 20 forced p1
      add(1,0,15'h10,0,     1,0,15'h20,0,        1,0,0, 1,0,16'hBEEF); // 21 back to p0
      idle(0,1,16'h1234);                                             // 22
      idle(1,0,16'hBEEF);                                             // 23
      idle(0,0,0);                                                    // 24
      for (int i = 0; i < 4; i++)                                     // 25-28 p0 stores win
         add(1,1,15'h30,16'h0001, 1,0,15'h10,0,  1,0,0, 0,0,0);
      add(1,1,15'h30,16'h0001, 0,0,0,0,          0,0,1, 0,0,0);      // 29 forfeit
      for (int i = 0; i < 4; i++)                                     // 30-33 count restarts at 0
         add(1,1,15'h30,16'h0002, 1,0,15'h10,0,  1,0,0, 0,0,0);
      add(1,1,15'h30,16'h0002, 1,0,15'h10,0,     0,1,1, 0,0,0);      // 34 forced p1 load
      idle(0,0,0);                                                    // 35
      idle(0,1,16'hBEEF);                                             // 36
      idle(0,0,0);                                                    // 37

      // Reset with requests asserted: everything quiet
      rst_n = 1'b0;
      drive(1,0,15'h10,0, 1,0,15'h20,0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1 chk_quiet($sformatf("rst%0d", i));
      end
      @(negedge clk);
      drive(0,0,0,0, 0,0,0,0);
      rst_n = 1'b1;

      foreach (vt[i]) begin
         v = vt[i];
         @(negedge clk);
         drive(v.req0, v.we0, v.a0, v.d0, v.req1, v.we1, v.a1, v.d1);
         #1;
         nm    = $sformatf("r%0d", i);
         ewen  = (v.g0 & v.we0) | (v.g1 & v.we1);
         eaddr = v.g0 ? v.a0 : (v.g1 ? v.a1 : 15'h0);
         edata = v.g0 ? v.d0 : v.d1;
         chk({nm, " gnt0"},    16'(bus.gnt0),    16'(v.g0));
         chk({nm, " gnt1"},    16'(bus.gnt1),    16'(v.g1));
         chk({nm, " stall0"},  16'(bus.stall0),  16'(v.st0));
         chk({nm, " rvalid0"}, 16'(bus.rvalid0), 16'(v.rv0));
         chk({nm, " rvalid1"}, 16'(bus.rvalid1), 16'(v.rv1));
         chk({nm, " mem_wen"}, 16'(mem_wen),     16'(ewen));
         chk({nm, " raddr"},   16'(mem_raddr),   16'(eaddr));
         if (ewen) begin
            chk({nm, " waddr"}, 16'(mem_waddr), 16'(eaddr));
            chk({nm, " wdata"}, mem_wdata,      edata);
         end
         if (v.rv0 | v.rv1) chk({nm, " rdata"}, bus.rdata, v.rd);
      end

      // Reset mid-load: grant a load, then reset before its response returns
      @(negedge clk);
      drive(1,0,15'h10,0, 0,0,0,0);
      #1 chk("midrst grant", 16'(bus.gnt0), 16'h1);
      @(negedge clk);
      drive(1,0,15'h10,0, 1,0,15'h20,0);
      rst_n = 1'b0;
      #1 chk_quiet("midrst a");
      @(negedge clk);
      #1 chk_quiet("midrst b");
      @(negedge clk);
      drive(0,0,0,0, 0,0,0,0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1 chk_quiet($sformatf("post%0d", i));
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
